// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline controller for the 5-stage core.
//
// Purpose: drives the enable/clear pair of every pipeline register and the
// PC enable, resolving data-memory wait states, multi-cycle MDU occupancy,
// taken-branch flushes and load-use hazards (highest priority first).
// Also produces EX-stage forwarding selects and a saturating count of the
// cycles in which the PC was held.
//
// Ports:
//   i_clock, i_reset_x           clock (rising edge), async active-low reset
//   i_id_rs1/2                   source regs of the instruction in ID
//   i_ex_rs1/2, i_ex_rd          source/dest regs of the instruction in EX
//   i_ex_mem_read                EX instruction is a load
//   i_ex_branch_taken            EX resolved a taken branch/jump
//   i_ex_mdu_op                  EX instruction is mul/div
//   i_mem_rd/i_wb_rd             dest regs in MEM / WB
//   i_mem_reg_write/i_wb_reg_write  MEM / WB instruction writes rd
//   i_mem_req, i_dmem_ready      data-memory access and its completion
//   o_pc_enable                  PC update enable
//   o_<stage>_enable/_clear      pipeline register controls (clear needs enable)
//   o_fwd_a/b                    EX operand select: 00 regfile, 01 WB, 10 MEM
//   o_mdu_done                   MDU result valid in EX this cycle
//   o_stall_count                saturating count of cycles with PC held
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no multi-cycle MDU op in progress
// MDU_BUSY | MDU op occupying EX; mdu_cnt stall cycles remain before done

module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MDU_LATENCY    = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset_x,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
  input  logic                      i_ex_mem_read,
  input  logic                      i_ex_branch_taken,
  input  logic                      i_ex_mdu_op,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
  input  logic                      i_mem_reg_write,
  input  logic                      i_wb_reg_write,
  input  logic                      i_mem_req,
  input  logic                      i_dmem_ready,
  output logic                      o_pc_enable,
  output logic                      o_ifid_enable,
  output logic                      o_ifid_clear,
  output logic                      o_idex_enable,
  output logic                      o_idex_clear,
  output logic                      o_exmem_enable,
  output logic                      o_exmem_clear,
  output logic                      o_memwb_enable,
  output logic                      o_memwb_clear,
  output logic [1:0]                o_fwd_a,
  output logic [1:0]                o_fwd_b,
  output logic                      o_mdu_done,
  output logic [CNT_WIDTH-1:0]      o_stall_count
);

  // Counter only has to hold MDU_LATENCY-2.
  localparam int MCW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY - 1) : 1;
  localparam logic [MCW-1:0] MDU_LOAD = MCW'((MDU_LATENCY > 2) ? (MDU_LATENCY - 2) : 0);
  localparam bit MDU_SINGLE = (MDU_LATENCY <= 1);

  typedef enum logic {IDLE, MDU_BUSY} state_t;

  state_t         state;
  logic [MCW-1:0] mdu_cnt;
  logic           mem_wait;
  logic           mdu_stall;
  logic           load_use;

  assign mem_wait = i_mem_req && !i_dmem_ready;

  assign load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                    ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

  always_comb begin
    mdu_stall  = 1'b0;
    o_mdu_done = 1'b0;
    if (state == IDLE) begin
      mdu_stall  = i_ex_mdu_op && !MDU_SINGLE;
      o_mdu_done = i_ex_mdu_op && MDU_SINGLE && !mem_wait;
    end else begin
      mdu_stall  = (mdu_cnt != '0);
      // Done only on the cycle the op actually leaves EX, not while frozen.
      o_mdu_done = (mdu_cnt == '0) && !mem_wait;
    end
  end

  always_comb begin
    o_pc_enable    = 1'b1;
    o_ifid_enable  = 1'b1;
    o_ifid_clear   = 1'b0;
    o_idex_enable  = 1'b1;
    o_idex_clear   = 1'b0;
    o_exmem_enable = 1'b1;
    o_exmem_clear  = 1'b0;
    o_memwb_enable = 1'b1;
    o_memwb_clear  = 1'b0;
    if (mem_wait) begin
      o_pc_enable    = 1'b0;
      o_ifid_enable  = 1'b0;
      o_idex_enable  = 1'b0;
      o_exmem_enable = 1'b0;
      o_memwb_clear  = 1'b1;
    end else if (mdu_stall) begin
      o_pc_enable    = 1'b0;
      o_ifid_enable  = 1'b0;
      o_idex_enable  = 1'b0;
      o_exmem_clear  = 1'b1;
    end else if (i_ex_branch_taken) begin
      // Squashing ID makes any load-use hazard against it moot.
      o_ifid_clear = 1'b1;
      o_idex_clear = 1'b1;
    end else if (load_use) begin
      o_pc_enable   = 1'b0;
      o_ifid_enable = 1'b0;
      o_idex_clear  = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == rs))
      return 2'b10;
    else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign o_fwd_a = fwd_sel(i_ex_rs1);
  assign o_fwd_b = fwd_sel(i_ex_rs2);

  always_ff @(posedge i_clock or negedge i_reset_x) begin
    if (!i_reset_x) begin
      state         <= IDLE;
      mdu_cnt       <= '0;
      o_stall_count <= '0;
    end else begin
      if (!mem_wait) begin
        if (state == IDLE) begin
          if (i_ex_mdu_op && !MDU_SINGLE) begin
            state   <= MDU_BUSY;
            mdu_cnt <= MDU_LOAD;
          end
        end else begin
          if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - MCW'(1);
          else
            state <= IDLE;
        end
      end
      if (!o_pc_enable && (o_stall_count != '1))
        o_stall_count <= o_stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int W   = 5;
  localparam int LAT = 4;

  logic         i_clock = 1'b0;
  logic         i_reset_x;
  logic [W-1:0] i_id_rs1, i_id_rs2, i_ex_rs1, i_ex_rs2, i_ex_rd, i_mem_rd, i_wb_rd;
  logic         i_ex_mem_read, i_ex_branch_taken, i_ex_mdu_op;
  logic         i_mem_reg_write, i_wb_reg_write, i_mem_req, i_dmem_ready;

  logic         pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic         exmem_en, exmem_clr, memwb_en, memwb_clr, mdu_done;
  logic [1:0]   fwd_a, fwd_b;
  logic [31:0]  stall_cnt;

  // Second instance: single-cycle MDU and a tiny counter to reach saturation.
  logic         pc_en2, ifid_en2, ifid_clr2, idex_en2, idex_clr2;
  logic         exmem_en2, exmem_clr2, memwb_en2, memwb_clr2, mdu_done2;
  logic [1:0]   fwd_a2, fwd_b2;
  logic [2:0]   stall_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 i_clock = ~i_clock;

  hazard_ctrl #(.REG_ADDR_WIDTH(W), .MDU_LATENCY(LAT), .CNT_WIDTH(32)) dut (
    .i_clock(i_clock), .i_reset_x(i_reset_x),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read), .i_ex_branch_taken(i_ex_branch_taken),
    .i_ex_mdu_op(i_ex_mdu_op), .i_mem_rd(i_mem_rd), .i_wb_rd(i_wb_rd),
    .i_mem_reg_write(i_mem_reg_write), .i_wb_reg_write(i_wb_reg_write),
    .i_mem_req(i_mem_req), .i_dmem_ready(i_dmem_ready),
    .o_pc_enable(pc_en), .o_ifid_enable(ifid_en), .o_ifid_clear(ifid_clr),
    .o_idex_enable(idex_en), .o_idex_clear(idex_clr),
    .o_exmem_enable(exmem_en), .o_exmem_clear(exmem_clr),
    .o_memwb_enable(memwb_en), .o_memwb_clear(memwb_clr),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_mdu_done(mdu_done), .o_stall_count(stall_cnt)
  );

  hazard_ctrl #(.REG_ADDR_WIDTH(W), .MDU_LATENCY(1), .CNT_WIDTH(3)) dut2 (
    .i_clock(i_clock), .i_reset_x(i_reset_x),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read), .i_ex_branch_taken(i_ex_branch_taken),
    .i_ex_mdu_op(i_ex_mdu_op), .i_mem_rd(i_mem_rd), .i_wb_rd(i_wb_rd),
    .i_mem_reg_write(i_mem_reg_write), .i_wb_reg_write(i_wb_reg_write),
    .i_mem_req(i_mem_req), .i_dmem_ready(i_dmem_ready),
    .o_pc_enable(pc_en2), .o_ifid_enable(ifid_en2), .o_ifid_clear(ifid_clr2),
    .o_idex_enable(idex_en2), .o_idex_clear(idex_clr2),
    .o_exmem_enable(exmem_en2), .o_exmem_clear(exmem_clr2),
    .o_memwb_enable(memwb_en2), .o_memwb_clear(memwb_clr2),
    .o_fwd_a(fwd_a2), .o_fwd_b(fwd_b2), .o_mdu_done(mdu_done2), .o_stall_count(stall_cnt2)
  );

  // Illegal stimulus combination must never be generated.
  always @(negedge i_clock)
    assert (!(i_ex_branch_taken && i_ex_mdu_op)) else $error("branch and mdu together");

  wire [8:0] ctrl = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                     exmem_en, exmem_clr, memwb_en, memwb_clr};

  localparam logic [8:0] C_DEF  = 9'b1_10_10_10_10;
  localparam logic [8:0] C_WAIT = 9'b0_00_00_00_11;
  localparam logic [8:0] C_MDU  = 9'b0_00_00_11_10;
  localparam logic [8:0] C_BR   = 9'b1_11_11_10_10;
  localparam logic [8:0] C_LU   = 9'b0_00_11_10_10;

  task automatic set_idle();
    i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rs1 = '0; i_ex_rs2 = '0; i_ex_rd = '0;
    i_mem_rd = '0; i_wb_rd = '0;
    i_ex_mem_read = 0; i_ex_branch_taken = 0; i_ex_mdu_op = 0;
    i_mem_reg_write = 0; i_wb_reg_write = 0; i_mem_req = 0; i_dmem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge i_clock); #1;
  endtask

  task automatic do_reset();
    set_idle();
    i_reset_x = 0;
    next_cycle(); next_cycle();
    i_reset_x = 1;
    next_cycle();
  endtask

  function automatic logic [1:0] ref_fwd(input logic [W-1:0] rs);
    if (i_mem_reg_write && i_mem_rd != 0 && i_mem_rd == rs) return 2'b10;
    if (i_wb_reg_write && i_wb_rd != 0 && i_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge i_clock);
    checks++; if (ctrl !== C_DEF) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_DEF); end
    checks++; if ({fwd_a, fwd_b, mdu_done} !== 5'b0) begin failures++; $display("FAIL reset_fwd_done got=%b%b%b exp=00000", fwd_a, fwd_b, mdu_done); end
    checks++; if (stall_cnt !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_load_use();
    i_ex_mem_read = 1; i_ex_rd = 5; i_id_rs2 = 5;
    @(negedge i_clock);
    checks++; if (ctrl !== C_LU) begin failures++; $display("FAIL load_use_ctrl got=%b exp=%b", ctrl, C_LU); end
    next_cycle();
    set_idle();
    @(negedge i_clock);
    checks++; if (stall_cnt !== 1) begin failures++; $display("FAIL load_use_count got=%0d exp=1", stall_cnt); end
    checks++; if (ctrl !== C_DEF) begin failures++; $display("FAIL load_use_release got=%b exp=%b", ctrl, C_DEF); end
    next_cycle();
    i_ex_mem_read = 1; i_ex_rd = 0; i_id_rs2 = 0; i_id_rs1 = 0;
    @(negedge i_clock);
    checks++; if (ctrl !== C_DEF) begin failures++; $display("FAIL load_use_x0 got=%b exp=%b", ctrl, C_DEF); end
    next_cycle();
    set_idle();
    @(negedge i_clock);
    checks++; if (stall_cnt !== 1) begin failures++; $display("FAIL load_use_x0_count got=%0d exp=1", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_forwarding();
    i_ex_rs1 = 7; i_ex_rs2 = 7; i_mem_rd = 7; i_wb_rd = 7;
    i_mem_reg_write = 1; i_wb_reg_write = 1;
    @(negedge i_clock);
    checks++; if (fwd_a !== 2'b10) begin failures++; $display("FAIL fwd_mem got=%b exp=10", fwd_a); end
    checks++; if (fwd_b !== 2'b10) begin failures++; $display("FAIL fwd_b_mem got=%b exp=10", fwd_b); end
    i_mem_reg_write = 0;
    @(negedge i_clock);
    checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL fwd_wb got=%b exp=01", fwd_a); end
    i_mem_reg_write = 1; i_mem_rd = 0; i_wb_rd = 0; i_ex_rs1 = 0;
    @(negedge i_clock);
    checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL fwd_x0 got=%b exp=00", fwd_a); end
    set_idle();
    next_cycle();
  endtask

  task automatic test_mdu();
    int base;
    do_reset();
    base = 0;
    i_ex_mdu_op = 1;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge i_clock);
      if (c < LAT) begin
        checks++; if (ctrl !== C_MDU || mdu_done !== 1'b0) begin failures++; $display("FAIL mdu_stall_c%0d got=%b/%b exp=%b/0", c, ctrl, mdu_done, C_MDU); end
      end else begin
        checks++; if (ctrl !== C_DEF || mdu_done !== 1'b1) begin failures++; $display("FAIL mdu_done_c%0d got=%b/%b exp=%b/1", c, ctrl, mdu_done, C_DEF); end
      end
      next_cycle();
    end
    i_ex_mdu_op = 0;
    @(negedge i_clock);
    checks++; if (ctrl !== C_DEF || mdu_done !== 1'b0) begin failures++; $display("FAIL mdu_after got=%b/%b exp=%b/0", ctrl, mdu_done, C_DEF); end
    checks++; if (stall_cnt !== base + LAT - 1) begin failures++; $display("FAIL mdu_count got=%0d exp=%0d", stall_cnt, base + LAT - 1); end
    next_cycle();
  endtask

  task automatic test_mdu_wait();
    int done_at;
    do_reset();
    done_at = 0;
    i_ex_mdu_op = 1;
    for (int c = 1; c <= 10 && done_at == 0; c++) begin
      i_mem_req = (c == 2 || c == 3);
      i_dmem_ready = 0;
      @(negedge i_clock);
      if (c == 2 || c == 3) begin
        checks++; if (ctrl !== C_WAIT || mdu_done !== 1'b0) begin failures++; $display("FAIL mdu_wait_c%0d got=%b/%b exp=%b/0", c, ctrl, mdu_done, C_WAIT); end
      end
      if (mdu_done === 1'b1) done_at = c;
      next_cycle();
    end
    set_idle();
    checks++; if (done_at !== LAT + 2) begin failures++; $display("FAIL mdu_wait_occupancy got=%0d exp=%0d", done_at, LAT + 2); end
    @(negedge i_clock);
    checks++; if (stall_cnt !== LAT + 1) begin failures++; $display("FAIL mdu_wait_count got=%0d exp=%0d", stall_cnt, LAT + 1); end
    next_cycle();
  endtask

  task automatic test_branch_over_load_use();
    do_reset();
    i_ex_branch_taken = 1; i_ex_mem_read = 1; i_ex_rd = 5; i_id_rs1 = 5;
    @(negedge i_clock);
    checks++; if (ctrl !== C_BR) begin failures++; $display("FAIL branch_lu got=%b exp=%b", ctrl, C_BR); end
    next_cycle();
    set_idle();
    @(negedge i_clock);
    checks++; if (stall_cnt !== 0) begin failures++; $display("FAIL branch_count got=%0d exp=0", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    i_ex_mdu_op = 1;
    next_cycle(); next_cycle();
    #2;
    set_idle();
    i_reset_x = 0;
    #1;
    checks++; if (ctrl !== C_DEF || stall_cnt !== 0) begin failures++; $display("FAIL async_reset got=%b/%0d exp=%b/0", ctrl, stall_cnt, C_DEF); end
    next_cycle();
    i_reset_x = 1;
    next_cycle();
    @(negedge i_clock);
    checks++; if (ctrl !== C_DEF || stall_cnt !== 0 || mdu_done !== 1'b0) begin failures++; $display("FAIL post_reset got=%b/%0d/%b exp=%b/0/0", ctrl, stall_cnt, mdu_done, C_DEF); end
    next_cycle();
  endtask

  task automatic test_lat1_saturate();
    do_reset();
    i_ex_mdu_op = 1;
    @(negedge i_clock);
    checks++; if (mdu_done2 !== 1'b1 || pc_en2 !== 1'b1 || exmem_clr2 !== 1'b0) begin failures++; $display("FAIL lat1_done got=%b%b%b exp=110", mdu_done2, pc_en2, exmem_clr2); end
    next_cycle();
    set_idle();
    i_ex_mem_read = 1; i_ex_rd = 3; i_id_rs1 = 3;
    for (int c = 0; c < 7; c++) next_cycle();
    @(negedge i_clock);
    checks++; if (stall_cnt2 !== 3'd7) begin failures++; $display("FAIL sat_reach got=%0d exp=7", stall_cnt2); end
    next_cycle(); next_cycle();
    @(negedge i_clock);
    checks++; if (stall_cnt2 !== 3'd7) begin failures++; $display("FAIL sat_hold got=%0d exp=7", stall_cnt2); end
    set_idle();
    next_cycle();
  endtask

  // Reference: an MDU op needs LAT non-wait cycles in EX; stall on all but the last.
  task automatic test_random();
    int occ_left;
    int m_cnt;
    int left;
    bit wait_c, active, stall_m, done_m, lu;
    logic [8:0] e;
    do_reset();
    occ_left = 0;
    m_cnt = 0;
    for (int c = 0; c < 500; c++) begin
      i_id_rs1 = W'($urandom_range(0, 7)); i_id_rs2 = W'($urandom_range(0, 7));
      i_ex_rs1 = W'($urandom_range(0, 7)); i_ex_rs2 = W'($urandom_range(0, 7));
      i_ex_rd  = W'($urandom_range(0, 7)); i_mem_rd = W'($urandom_range(0, 7));
      i_wb_rd  = W'($urandom_range(0, 7));
      i_ex_mem_read = 1'($urandom_range(0, 1));
      i_mem_reg_write = 1'($urandom_range(0, 1));
      i_wb_reg_write = 1'($urandom_range(0, 1));
      i_mem_req = 1'($urandom_range(0, 1));
      i_dmem_ready = 1'($urandom_range(0, 1));
      if (occ_left > 0) i_ex_mdu_op = 1;
      else i_ex_mdu_op = ($urandom_range(0, 5) == 0);
      i_ex_branch_taken = i_ex_mdu_op ? 1'b0 : ($urandom_range(0, 3) == 0);

      wait_c = i_mem_req && !i_dmem_ready;
      active = (occ_left > 0) || i_ex_mdu_op;
      left = (occ_left > 0) ? occ_left : LAT;
      stall_m = active && left > 1;
      done_m = active && left == 1 && !wait_c;
      lu = i_ex_mem_read && i_ex_rd != 0 && (i_ex_rd == i_id_rs1 || i_ex_rd == i_id_rs2);
      if (wait_c) e = C_WAIT;
      else if (stall_m) e = C_MDU;
      else if (i_ex_branch_taken) e = C_BR;
      else if (lu) e = C_LU;
      else e = C_DEF;

      @(negedge i_clock);
      checks++; if (ctrl !== e) begin failures++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, ctrl, e); end
      checks++; if (fwd_a !== ref_fwd(i_ex_rs1) || fwd_b !== ref_fwd(i_ex_rs2)) begin failures++; $display("FAIL rnd_fwd c=%0d got=%b/%b exp=%b/%b", c, fwd_a, fwd_b, ref_fwd(i_ex_rs1), ref_fwd(i_ex_rs2)); end
      checks++; if (mdu_done !== done_m) begin failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, mdu_done, done_m); end
      checks++; if (stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt); end

      if (e[8] == 1'b0) m_cnt++;
      if (!wait_c && active) occ_left = left - 1;
      next_cycle();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    i_reset_x = 0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_mdu();
    test_mdu_wait();
    test_branch_over_load_use();
    test_reset_mid_mdu();
    test_lat1_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Drives the per-stage enable/clear pairs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. Handles load-use stalls, taken-branch flushes, multi-cycle MDU occupancy and data-memory wait states.
- Also produces EX-stage forwarding selects and a saturating stall-cycle counter.
- Pipeline-register semantics: clear acts only while enable=1; enable=0 holds.

Parameters:
REG_ADDR_WIDTH, 5, register-file address width
MDU_LATENCY, 4, total cycles an MDU op occupies EX (>=1)
CNT_WIDTH, 32, stall counter width

Ports:
i_clock  in  1  clock, rising edge
i_reset_x  in  1  asynchronous active-low reset
i_id_rs1, i_id_rs2  in  REG_ADDR_WIDTH  source regs of instruction in ID
i_ex_rs1, i_ex_rs2  in  REG_ADDR_WIDTH  source regs of instruction in EX
i_ex_rd  in  REG_ADDR_WIDTH  dest of EX instruction
i_ex_mem_read  in  1  EX instruction is a load
i_ex_branch_taken  in  1  EX resolved a taken branch/jump
i_ex_mdu_op  in  1  EX instruction is mul/div
i_mem_rd, i_wb_rd  in  REG_ADDR_WIDTH  dest regs in MEM, WB
i_mem_reg_write, i_wb_reg_write  in  1  MEM/WB instruction writes rd
i_mem_req  in  1  MEM stage issues a data-memory access
i_dmem_ready  in  1  data memory completes access this cycle
o_pc_enable  out  1  PC update enable
o_ifid_enable, o_ifid_clear  out  1 each
o_idex_enable, o_idex_clear  out  1 each
o_exmem_enable, o_exmem_clear  out  1 each
o_memwb_enable, o_memwb_clear  out  1 each
o_fwd_a, o_fwd_b  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM
o_mdu_done  out  1  MDU result valid in EX this cycle
o_stall_count  out  CNT_WIDTH  cycles with o_pc_enable=0

Behaviour:
- State: FSM {IDLE, MDU_BUSY}, down-counter mdu_cnt, stall counter. Reset: IDLE, mdu_cnt=0, o_stall_count=0. With reset state and all inputs 0: all enables=1, all clears=0, o_fwd_*=00, o_mdu_done=0.
- Default (no condition): all enables=1, clears=0.
- Priority, highest first: MEM_WAIT > MDU stall > branch flush > load-use.
- MEM_WAIT (i_mem_req && !i_dmem_ready): pc/ifid/idex/exmem enable=0; memwb enable=1 clear=1 (bubble to WB). The FSM and mdu_cnt hold.
- MDU stall, IDLE with i_ex_mdu_op and MDU_LATENCY>1: the stall is asserted and the FSM moves to MDU_BUSY with mdu_cnt=MDU_LATENCY-2.
- MDU stall, MDU_BUSY with mdu_cnt!=0: the stall is asserted and mdu_cnt decrements.
- MDU stall, MDU_BUSY with mdu_cnt==0: no stall, o_mdu_done=1, FSM goes to IDLE.
- MDU stall outputs: pc/ifid/idex enable=0; exmem enable=1 clear=1; memwb normal.
- MDU timing: the instruction occupies EX exactly MDU_LATENCY non-wait cycles. With MDU_LATENCY=1 there is no stall and o_mdu_done=1 combinationally whenever i_ex_mdu_op.
- Branch flush (i_ex_branch_taken): ifid and idex enable=1 clear=1; PC enabled (loads target). Branch overrides load-use, because the ID instruction is squashed.
- Load-use: i_ex_mem_read and i_ex_rd!=0 and (i_ex_rd==i_id_rs1 or i_ex_rd==i_id_rs2). Outputs: pc/ifid enable=0; idex enable=1 clear=1; exmem/memwb normal. Exactly 1 stall cycle per hazard.
- i_ex_branch_taken and i_ex_mdu_op together are illegal. The bench asserts they never coincide; the RTL gives MDU priority.
- Forwarding (combinational, independent of stalls): o_fwd_a=10 if i_mem_reg_write and i_mem_rd!=0 and i_mem_rd==i_ex_rs1; else 01 if the same test passes for WB; else 00. o_fwd_b is identical using i_ex_rs2. MEM beats WB; x0 never forwards.
- o_stall_count increments on each clock edge where o_pc_enable=0. It saturates at all-ones.
- Reset mid-operation (e.g. in MDU_BUSY or during MEM_WAIT) returns the FSM to IDLE and the counters to 0 immediately and asynchronously. Outputs revert to defaults with no glitch-to-stall after deassertion.

Test Plan:
- Reset then idle inputs -> all enables=1, clears=0, fwd=00, o_stall_count=0.
- Load-use: i_ex_mem_read=1, i_ex_rd=5, i_id_rs2=5 for 1 cycle -> pc/ifid enable=0, idex clear=1 for one cycle; o_stall_count=1. Repeat with i_ex_rd=0 -> no stall.
- Forwarding: i_ex_rs1=7, mem_rd=7 and wb_rd=7 both writing -> o_fwd_a=10. Drop mem_reg_write -> 01. Set both rd=0 -> 00.
- MDU_LATENCY=4: i_ex_mdu_op held -> 3 stall cycles (exmem clear=1), o_mdu_done=1 on 4th cycle, state IDLE after; o_stall_count=3.
- MDU op with MEM_WAIT for 2 cycles mid-count -> total EX occupancy 6 cycles; memwb clear=1 during the waits; o_mdu_done still on the last cycle.
- Branch taken coinciding with load-use -> ifid and idex clear=1, pc enable=1, no stall. Async reset asserted in MDU_BUSY -> outputs return to defaults, o_stall_count=0.
